// File: rtl/dsp_common_pkg.sv
// Shared DSP helpers: width arithmetic and channel slicing used by the
// receiver's correlation, energy and averaging blocks.
`ifndef DSP_CH_SLICE
`define DSP_CH_SLICE(vec, ch, w) vec[(ch)*(w) +: (w)]
`endif

package dsp_common_pkg;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of a window sum that cannot overflow for windows up to 2^max_log2.
  function automatic int sum_width(input int data_width, input int max_log2);
    return data_width + max_log2;
  endfunction

endpackage

// File: rtl/ring_ram_rf.sv
// Single-clock read-first RAM: one shared address, write and synchronous read
// on the same edge, so the read word is the contents before the write.
module ring_ram_rf #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_reg [0:(1 << DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rdata_reg;

  // No reset on the array or its read register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_reg     <= mem_reg[addr];
      mem_reg[addr] <= wdata;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/window_accumulator.sv
// Multi-channel power-of-two sliding-window sum and rounded average with a
// fixed two-cycle latency from each accepted sample.
module window_accumulator
  import dsp_common_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int MAX_LOG2   = 6
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              enable,
  input  logic [clogb2(MAX_LOG2):0]                         win_log2,
  input  logic                                              sample_in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                      sample_in,
  output logic                                              acc_avg_out_valid,
  output logic [NUM_CH*sum_width(DATA_WIDTH, MAX_LOG2)-1:0] acc_sum_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]                      acc_avg_out,
  output logic                                              window_full
);

  localparam int SW = sum_width(DATA_WIDTH, MAX_LOG2);
  localparam int LW = clogb2(MAX_LOG2) + 1;
  localparam int WW = NUM_CH * DATA_WIDTH;
  localparam int PW = MAX_LOG2;
  localparam logic [LW-1:0] MAX_LOG2_Q = LW'(MAX_LOG2);

  logic [LW-1:0] win_log2_reg;
  logic [LW-1:0] win_log2_clamped;
  logic [PW:0]   win_n;
  logic [PW:0]   half_n;
  logic [PW-1:0] ptr_mask;
  logic          win_is_one;

  logic          accept;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [PW:0]   fill_cnt_reg, fill_cnt_next;
  logic [WW-1:0] new_reg;
  logic [WW-1:0] fwd_reg;
  logic [WW-1:0] ram_rdata;
  logic [WW-1:0] old_word;
  logic          s1_valid_reg, s1_mask_reg, s1_full_reg;
  logic          s2_valid_reg, s2_full_reg;
  logic          valid_out_reg, full_out_reg;

  assign win_log2_clamped = (win_log2 > MAX_LOG2_Q) ? MAX_LOG2_Q : win_log2;
  assign win_n            = {{PW{1'b0}}, 1'b1} << win_log2_reg;
  assign half_n           = win_n >> 1;
  assign ptr_mask         = ~({PW{1'b1}} << win_log2_reg);
  assign win_is_one       = (win_log2_reg == '0);

  assign accept        = enable & sample_in_valid;
  assign ptr_next      = (ptr_reg + 1'b1) & ptr_mask;
  assign fill_cnt_next = (fill_cnt_reg == win_n) ? fill_cnt_reg : fill_cnt_reg + 1'b1;

  // A one-deep window would read back the word written on the previous edge,
  // so take the previous sample straight from the forwarding register instead.
  assign old_word = win_is_one ? fwd_reg : ram_rdata;

  ring_ram_rf #(
    .DEPTH_LOG2 (PW),
    .WIDTH      (WW)
  ) u_ring_ram (
    .clk   (clk),
    .en    (accept),
    .addr  (ptr_reg),
    .wdata (sample_in),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_log2_reg <= MAX_LOG2_Q;
      ptr_reg      <= '0;
      fill_cnt_reg <= '0;
      new_reg      <= '0;
      fwd_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_mask_reg  <= 1'b0;
      s1_full_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_full_reg  <= 1'b0;
    end else if (!enable) begin
      win_log2_reg <= win_log2_clamped;
      ptr_reg      <= '0;
      fill_cnt_reg <= '0;
      new_reg      <= '0;
      fwd_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_mask_reg  <= 1'b0;
      s1_full_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_full_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
      s2_full_reg  <= s1_full_reg;
      if (accept) begin
        ptr_reg      <= ptr_next;
        fill_cnt_reg <= fill_cnt_next;
        fwd_reg      <= new_reg;
        new_reg      <= sample_in;
        // The old word is garbage until N samples have been written.
        s1_mask_reg  <= (fill_cnt_reg != win_n);
        s1_full_reg  <= (fill_cnt_next == win_n);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_reg <= 1'b0;
      full_out_reg  <= 1'b0;
    end else if (!enable) begin
      valid_out_reg <= 1'b0;
      full_out_reg  <= 1'b0;
    end else begin
      valid_out_reg <= s2_valid_reg;
      if (s2_valid_reg && s2_full_reg) full_out_reg <= 1'b1;
    end
  end

  assign acc_avg_out_valid = valid_out_reg;
  assign window_full       = full_out_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int LO = gi * DATA_WIDTH;

      logic [SW-1:0]         new_ext;
      logic [SW-1:0]         old_ext;
      logic [SW-1:0]         sum_reg, sum_next;
      logic [SW-1:0]         round_val;
      logic [DATA_WIDTH-1:0] avg_next;
      logic [SW-1:0]         sum_out_reg;
      logic [DATA_WIDTH-1:0] avg_out_reg;

      assign new_ext  = {{MAX_LOG2{new_reg[LO+DATA_WIDTH-1]}}, new_reg[LO +: DATA_WIDTH]};
      assign old_ext  = s1_mask_reg ? '0 :
                        {{MAX_LOG2{old_word[LO+DATA_WIDTH-1]}}, old_word[LO +: DATA_WIDTH]};
      assign sum_next = sum_reg + new_ext - old_ext;

      // Round half up, then an arithmetic shift by win_log2 truncated to
      // DATA_WIDTH is the same as picking DATA_WIDTH bits starting at win_log2;
      // the rounded sum always fits in SW bits.
      assign round_val = sum_reg + {{(SW-PW-1){1'b0}}, half_n};
      assign avg_next  = round_val[win_log2_reg +: DATA_WIDTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_reg <= '0;
        end else if (!enable) begin
          sum_reg <= '0;
        end else if (s1_valid_reg) begin
          sum_reg <= sum_next;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_out_reg <= '0;
          avg_out_reg <= '0;
        end else if (!enable) begin
          sum_out_reg <= '0;
          avg_out_reg <= '0;
        end else if (s2_valid_reg) begin
          sum_out_reg <= sum_reg;
          avg_out_reg <= avg_next;
        end
      end

      assign acc_sum_out[gi*SW +: SW]         = sum_out_reg;
      assign acc_avg_out[LO +: DATA_WIDTH]    = avg_out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator: directed scenarios plus randomized streams,
// all outputs checked against a queue-based window model.
module tb_window_accumulator;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int ML = 6;
  localparam int SW = DW + ML;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [LW-1:0]     win_log2 = '0;
  logic              sample_in_valid = 1'b0;
  logic [NC*DW-1:0]  sample_in = '0;
  logic              acc_avg_out_valid;
  logic [NC*SW-1:0]  acc_sum_out;
  logic [NC*DW-1:0]  acc_avg_out;
  logic              window_full;

  window_accumulator #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_LOG2(ML)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .win_log2          (win_log2),
    .sample_in_valid   (sample_in_valid),
    .sample_in         (sample_in),
    .acc_avg_out_valid (acc_avg_out_valid),
    .acc_sum_out       (acc_sum_out),
    .acc_avg_out       (acc_avg_out),
    .window_full       (window_full)
  );

  always #5 clk = ~clk;

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  typedef struct {
    int     due;
    longint s0, s1, a0, a1;
    bit     full;
  } exp_t;

  exp_t   exp_q[$];
  longint hist0[$], hist1[$];
  int     model_log2 = ML;
  int     acc_cnt = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  longint last_s0 = 0, last_s1 = 0, last_a0 = 0, last_a1 = 0;
  int     seg_out = 0;
  int     full_at = 0;

  task automatic check(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, got, want, pe);
  endtask

  function automatic longint win_sum(input longint h[$], input int n);
    longint s;
    int lo;
    s  = 0;
    lo = (h.size() > n) ? h.size() - n : 0;
    for (int i = lo; i < h.size(); i++) s += h[i];
    return s;
  endfunction

  // Round half up: floor((s + N/2) / N) with true floor for negatives.
  function automatic longint ref_avg(input longint s, input int lg);
    longint n, num, q;
    n   = longint'(1) << lg;
    num = s + n / 2;
    q   = num / n;
    if ((num % n != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_clear();
    hist0.delete();
    hist1.delete();
    acc_cnt = 0;
    exp_q.delete();
  endfunction

  // One clock: drive inputs, let the edge happen, update the model.
  task automatic step(input bit en, input bit v, input int d0, input int d1);
    logic signed [DW-1:0] t0, t1;
    int   n;
    exp_t e;
    t0 = DW'(d0);
    t1 = DW'(d1);
    enable          = en;
    sample_in_valid = v;
    sample_in       = {t1, t0};
    @(posedge clk);
    #1;
    if (!en) begin
      model_log2 = (win_log2 > LW'(ML)) ? ML : int'(win_log2);
      model_clear();
    end else if (v) begin
      hist0.push_back(longint'(t0));
      hist1.push_back(longint'(t1));
      if (hist0.size() > 64) begin
        void'(hist0.pop_front());
        void'(hist1.pop_front());
      end
      acc_cnt++;
      n      = 1 << model_log2;
      e.due  = pe + 2;
      e.s0   = win_sum(hist0, n);
      e.s1   = win_sum(hist1, n);
      e.a0   = ref_avg(e.s0, model_log2);
      e.a1   = ref_avg(e.s1, model_log2);
      e.full = (acc_cnt >= n);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  task automatic configure(input int lg);
    win_log2 = LW'(lg);
    step(1'b0, 1'b0, 0, 0);
    seg_out = 0;
    full_at = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"},   longint'(acc_sum_out), 0);
    check({tag, "_avg"},   longint'(acc_avg_out), 0);
    check({tag, "_valid"}, longint'(acc_avg_out_valid), 0);
    check({tag, "_full"},  longint'(window_full), 0);
  endtask

  // Output monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    logic signed [SW-1:0] s0, s1;
    logic signed [DW-1:0] a0, a1;
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].due < pe) begin
        check("missing_strobe", longint'(pe), longint'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (acc_avg_out_valid) begin
        s0 = acc_sum_out[SW-1:0];
        s1 = acc_sum_out[2*SW-1:SW];
        a0 = acc_avg_out[DW-1:0];
        a1 = acc_avg_out[2*DW-1:DW];
        if (exp_q.size() == 0) begin
          check("spurious_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", longint'(pe), longint'(e.due));
          check("sum0", longint'(s0), e.s0);
          check("sum1", longint'(s1), e.s1);
          check("avg0", longint'(a0), e.a0);
          check("avg1", longint'(a1), e.a1);
          check("window_full", longint'(window_full), longint'(e.full));
          seg_out++;
          if (window_full && full_at == 0) full_at = seg_out;
          last_s0 = longint'(s0);
          last_s1 = longint'(s1);
          last_a0 = longint'(a0);
          last_a1 = longint'(a1);
          $display("out edge=%0d sum=(%0d,%0d) avg=(%0d,%0d) full=%0b",
                   pe, s0, s1, a0, a1, window_full);
        end
      end
    end
  end

  initial begin
    int r0, r1, lg;

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill and steady state, N=16.
    configure(4);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 100, -100);
    idle(3);
    check("fill_sum0", last_s0, 1600);
    check("fill_sum1", last_s1, -1600);
    check("fill_avg0", last_a0, 100);
    check("fill_avg1", last_a1, -100);
    check("fill_full_rise", longint'(full_at), 16);
    check("fill_count", longint'(seg_out), 20);

    // Step response.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, -100, 100);
    idle(3);
    check("step_sum0", last_s0, -1600);
    check("step_avg0", last_a0, -100);
    check("step_full", longint'(window_full), 1);

    // Gapped ramp, N=8.
    configure(3);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, i, -i);
      idle(2);
    end
    idle(2);
    check("gap_sum0", last_s0, 132);
    check("gap_avg0", last_a0, 17);
    check("gap_avg1", last_a1, -16);
    check("gap_count", longint'(seg_out), 20);

    // Rounding and extremes, N=2.
    configure(1);
    step(1'b1, 1'b1, 1, -1);
    step(1'b1, 1'b1, 2, -2);
    idle(3);
    check("rnd_sum0", last_s0, 3);
    check("rnd_avg0", last_a0, 2);
    check("rnd_sum1", last_s1, -3);
    check("rnd_avg1", last_a1, -1);
    configure(1);
    step(1'b1, 1'b1, 32767, -32768);
    step(1'b1, 1'b1, 32767, -32768);
    idle(3);
    check("max_avg0", last_a0, 32767);
    check("min_sum1", last_s1, -65536);
    check("min_avg1", last_a1, -32768);

    // N=1: average follows the input.
    configure(0);
    for (int i = 0; i < 6; i++) begin
      r0 = int'($urandom_range(0, 65535)) - 32768;
      r1 = int'($urandom_range(0, 65535)) - 32768;
      step(1'b1, 1'b1, r0, r1);
    end
    idle(3);
    check("n1_avg0", last_a0, longint'(r0));
    check("n1_avg1", last_a1, longint'(r1));

    // Reconfigure with samples in flight.
    configure(4);
    for (int i = 0; i < 18; i++)
      step(1'b1, 1'b1, int'($urandom_range(0, 2000)), -int'($urandom_range(0, 2000)));
    win_log2 = LW'(3);
    step(1'b0, 1'b1, 5, 5);
    check_zero("disable");
    seg_out = 0;
    full_at = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, int'($urandom_range(0, 2000)), -int'($urandom_range(0, 2000)));
    idle(3);
    check("refill_full_rise", longint'(full_at), 8);

    // Randomized streams; win_log2 toggles while enabled must be ignored.
    for (int r = 0; r < 6; r++) begin
      configure(int'($urandom_range(0, 7)));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) == 0) win_log2 = LW'($urandom_range(0, 15));
        if ($urandom_range(0, 79) == 0) begin
          win_log2 = LW'($urandom_range(0, 7));
          step(1'b0, 1'b0, 0, 0);
        end else begin
          step(1'b1, ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768);
        end
      end
      idle(3);
    end

    // Asynchronous reset mid-stream.
    configure(2);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, int'($urandom_range(0, 999)), int'($urandom_range(0, 999)));
    #2 rst = 1'b1;
    enable = 1'b0;
    sample_in_valid = 1'b0;
    model_clear();
    model_log2 = ML;
    #1 check_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    configure(2);
    step(1'b1, 1'b1, 50, -50);
    idle(3);
    check("post_rst_sum0", last_s0, 50);
    check("post_rst_avg0", last_a0, 13);
    check("post_rst_avg1", last_a1, -12);

    idle(4);
    check("pending_outputs", longint'(exp_q.size()), 0);
    lg = n_chk;
    $display("%0d/%0d checks passed", n_pass, lg);
    $finish;
  end

endmodule

// File: doc/window_accumulator.md
# window_accumulator

Parametrised multi-channel sliding-window accumulator and averager for the OFDM receiver's correlation and power paths. It sits after the delay-correlation and energy stages of short-training-sequence detection and feeds the threshold comparator. It generalises the fixed-depth, single-channel moving average in three ways: NUM_CH independent channels share one ring buffer, the window length is runtime-selectable as a power of two, and it outputs both the full-precision window sum and a rounded average. Output latency is fixed at 2 cycles from every accepted sample, including during window fill.

## Interface
- DATA_WIDTH, 16: width of one signed two's-complement channel sample.
- NUM_CH, 2: number of independent channels (e.g. I/Q, or correlation plus energy).
- MAX_LOG2, 6: log2 of the maximum window depth; the ring buffer depth is 2^MAX_LOG2.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  operate when high; low synchronously clears all state.
- win_log2  in  clogb2(MAX_LOG2)+1  window N = 2^win_log2; captured only while enable=0.
- sample_in_valid  in  1  sample strobe; there is no backpressure.
- sample_in  in  NUM_CH*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- acc_avg_out_valid  out  1  one-cycle strobe per accepted sample.
- acc_sum_out  out  NUM_CH*(DATA_WIDTH+MAX_LOG2)  signed window sum per channel.
- acc_avg_out  out  NUM_CH*DATA_WIDTH  rounded average per channel.
- window_full  out  1  high once N samples have been accepted since enable rose.

## Operation
- **Reset** (async): pointer, fill count, sums, pipeline registers and all outputs go to 0. win_log2_q goes to MAX_LOG2.
- **enable=0**: clears the same state synchronously on the next edge. win_log2_q <= min(win_log2, MAX_LOG2) every cycle. No outputs are produced.
- **enable=1**: win_log2_q is frozen. A sample is accepted only when sample_in_valid=1.
- **Ring buffer**
  - Holds NUM_CH*DATA_WIDTH per word. ptr runs 0..N-1 and wraps to 0 after N-1.
  - On an accepted sample, the RAM reads and writes the same address ptr, read-first, so the read word is the sample N accepts old.
  - For N=1 the old word is the previous sample, so sum = current sample.
- **Fill**
  - fill_cnt counts accepted samples, saturating at N.
  - While fill_cnt < N (evaluated at acceptance), the old sample is masked to 0, because RAM contents are undefined after reset.
  - window_full rises with the output of the Nth accepted sample and stays high until enable=0 or rst.
- **Arithmetic** (per channel, SW = DATA_WIDTH+MAX_LOG2)
  - sum <= sum + sext(new) - sext(old_masked).
  - Over N samples, |sum| ≤ N*2^(DATA_WIDTH-1), so no overflow is possible.
  - avg = (sum + (N>>1)) >>> win_log2, truncated to DATA_WIDTH. This is round-half-up; it cannot overflow for any N.
  - During fill, avg is still divided by N (a scaled partial average).
- **Idle cycles**: sum and ptr hold, and no output strobe is produced.

## Timing
- **Cycle k**: sample accepted; RAM read issued; new sample registered.
- **Cycle k+1**: old word available; sum register updated.
- **Cycle k+2**: acc_sum_out, acc_avg_out and acc_avg_out_valid registered. Latency is exactly 2 cycles for every accepted sample, including the first one.
- **Throughput**: one sample per cycle sustained. Back-to-back samples at the same ptr cannot occur for N≥2. For N=1, the old word comes from the forwarded previous sample, not the RAM.
- **enable falling** with samples in flight: the in-flight strobes are dropped; no output appears at k+1 or k+2.
- **Outputs between strobes**: hold their last value. They are 0 after reset or disable.
- **rst mid-stream**: outputs are 0 immediately, with no clock edge needed.

## Structure
- Shared package/header dsp_common_pkg holds:
  - the clogb2 function;
  - an SW width helper;
  - the channel slice macro, also used by the correlator blocks.
- Sub-module ring_ram_rf: read-first single-clock RAM (one write port plus one synchronous read port, DEPTH = 2^MAX_LOG2, width NUM_CH*DATA_WIDTH), inferable as BRAM or LUTRAM.
- Top level contains: ptr/fill control, per-channel generate loop for sum/avg, and the valid pipeline.

## Test plan
- **Fill and steady state**: NUM_CH=2, win_log2=4, 20 consecutive samples, ch0=100, ch1=-100.
  - Sums: ±100, ±200, …, ±1600, then hold at ±1600.
  - avg ch0: 6, 13, 19, … → 100.
  - window_full rises on output 16.
  - Every output appears exactly 2 cycles after its sample.
- **Step response**: after full at ch0=100, drive 16 samples of -100.
  - Sum falls by 200 per sample to -1600; avg ends at -100.
  - window_full stays high.
- **Gapped input**: valid every 3rd cycle, ramp 1..20, N=8.
  - One strobe per valid, each at +2 cycles.
  - Sum after the 20th sample = 13+…+20 = 132; avg = 17.
- **Rounding and extremes**: DATA_WIDTH=16, N=2.
  - Inputs 1, 2: final sum 3, avg 2.
  - Inputs -1, -2: sum -3, avg -1.
  - Inputs 32767 ×2: avg 32767.
  - Inputs -32768 ×2: sum -65536, avg -32768.
  - N=1: avg equals the input.
- **Reconfigure and disable**: N=16 full, drop enable for 1 cycle with win_log2=3.
  - In-flight strobes are suppressed.
  - Outputs read 0; window_full=0.
  - A new fill of 8 follows; window_full rises on output 8.
- **Async reset mid-stream**: rst pulsed between clock edges.
  - All outputs are 0 before the next edge.
  - After release and enable, the first sample of 50 (N=4) gives sum 50, avg 13.
